// File: rtl/multi_channel_pulse_width_detector_if.sv
// Bundle of per-channel samples, enables, run-time mode/window and detector outputs.
// The master drives the inputs and observes results; the slave is the detector itself.
interface multi_channel_pulse_width_detector_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned LEN_W = 4
);
  logic [N_CH-1:0]       a;
  logic [N_CH-1:0]       en;
  logic [1:0]            mode;
  logic [LEN_W-1:0]      min_len;
  logic [LEN_W-1:0]      max_len;
  logic [N_CH-1:0]       detected;
  logic [N_CH*LEN_W-1:0] last_len;
  logic [N_CH-1:0]       overlong;

  modport master (
    output a, en, mode, min_len, max_len,
    input  detected, last_len, overlong
  );

  modport slave (
    input  a, en, mode, min_len, max_len,
    output detected, last_len, overlong
  );
endinterface

// File: rtl/multi_channel_pulse_width_detector.sv
// N_CH independent edge / pulse-width detectors with a shared run-time mode and window.
// Each channel tracks its previous sample, a saturating high-run counter and last length.
module multi_channel_pulse_width_detector #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 2)
) (
  input logic                                 clk,
  input logic                                 rst,
  multi_channel_pulse_width_detector_if.slave bus
);

  // Counter value meaning "longer than MAX_LEN"; never matches the pulse window.
  localparam logic [LEN_W-1:0] SatLen = LEN_W'(MAX_LEN + 1);

  logic [N_CH-1:0]             a_d, a_q;
  logic [N_CH-1:0][LEN_W-1:0]  cnt_d, cnt_q;
  logic [N_CH-1:0][LEN_W-1:0]  last_len_d, last_len_q;
  logic [N_CH-1:0]             overlong_d, overlong_q;
  logic [N_CH-1:0]             detected;
  logic [N_CH-1:0]             rf;
  logic [LEN_W-1:0]            win_lo;

  assign rf     = a_q & ~bus.a;
  assign win_lo = (bus.min_len == '0) ? LEN_W'(1) : bus.min_len;

  always_comb begin
    a_d        = bus.a;
    cnt_d      = '0;
    last_len_d = last_len_q;
    overlong_d = overlong_q;
    detected   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (bus.en[i]) begin
        if (bus.a[i]) begin
          cnt_d[i] = (cnt_q[i] == SatLen) ? SatLen : cnt_q[i] + LEN_W'(1);
        end
        if (rf[i]) begin
          last_len_d[i] = cnt_q[i];
          if (cnt_q[i] == SatLen) begin
            overlong_d[i] = 1'b1;
          end
        end
        unique case (bus.mode)
          2'b00: detected[i] = bus.a[i] & ~a_q[i];
          2'b01: detected[i] = rf[i];
          2'b10: detected[i] = bus.a[i] ^ a_q[i];
          2'b11: detected[i] = rf[i] && (cnt_q[i] >= win_lo) && (cnt_q[i] <= bus.max_len) &&
                               (cnt_q[i] != SatLen);
          default: detected[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      cnt_q      <= '0;
      last_len_q <= '0;
      overlong_q <= '0;
    end else begin
      a_q        <= a_d;
      cnt_q      <= cnt_d;
      last_len_q <= last_len_d;
      overlong_q <= overlong_d;
    end
  end

  assign bus.detected = detected;
  assign bus.last_len = last_len_q;
  assign bus.overlong = overlong_q;

endmodule

// File: tb/tb_multi_channel_pulse_width_detector.sv
// Bench for the multi-channel pulse-width detector: directed scenarios plus random traffic,
// compared against a sample-history reference model.
module tb_multi_channel_pulse_width_detector;

  localparam int NCh    = 4;
  localparam int MaxLen = 8;
  localparam int LenW   = 4;

  logic clk;
  logic rst;

  multi_channel_pulse_width_detector_if #(.N_CH(NCh), .LEN_W(LenW)) bus ();

  multi_channel_pulse_width_detector #(
    .N_CH   (NCh),
    .MAX_LEN(MaxLen),
    .LEN_W  (LenW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Reference model: enabled-sample history per channel, previous raw sample, captures.
  bit   hist [NCh][$];
  bit   prev [NCh];
  int   lastlen [NCh];
  bit   ovl [NCh];
  logic [NCh-1:0] last_det;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Length of the high run ending at the latest enabled sample, capped at MAX_LEN+1.
  function automatic int trail(int ch);
    int n = 0;
    for (int k = hist[ch].size() - 1; k >= 0; k--) begin
      if (!hist[ch][k]) break;
      n++;
    end
    return (n > MaxLen + 1) ? MaxLen + 1 : n;
  endfunction

  task automatic model_clear();
    for (int ch = 0; ch < NCh; ch++) begin
      hist[ch].delete();
      prev[ch]    = 1'b0;
      lastlen[ch] = 0;
      ovl[ch]     = 1'b0;
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] en, input logic [1:0] mode,
                       input logic [3:0] mn, input logic [3:0] mx);
    bus.a       = a;
    bus.en      = en;
    bus.mode    = mode;
    bus.min_len = mn;
    bus.max_len = mx;
  endtask

  task automatic check_regs(input string tag);
    logic [15:0] ell;
    logic [3:0]  eo;
    for (int ch = 0; ch < NCh; ch++) begin
      ell[ch*LenW +: LenW] = lastlen[ch][LenW-1:0];
      eo[ch]               = ovl[ch];
    end
    check({tag, ".last_len"}, 64'(bus.last_len), 64'(ell));
    check({tag, ".overlong"}, 64'(bus.overlong), 64'(eo));
  endtask

  // One clock: check detected mid-cycle, advance the model, check captured registers.
  task automatic step(input string tag);
    logic [3:0] ed;
    int         lo;
    int         len;
    bit         ai;
    bit         rfall;
    ed = '0;
    lo = (bus.min_len == 0) ? 1 : int'(bus.min_len);
    for (int ch = 0; ch < NCh; ch++) begin
      ai    = bus.a[ch];
      rfall = prev[ch] && !ai;
      len   = trail(ch);
      if (bus.en[ch]) begin
        case (bus.mode)
          2'd0: ed[ch] = ai && !prev[ch];
          2'd1: ed[ch] = rfall;
          2'd2: ed[ch] = ai != prev[ch];
          default: ed[ch] = rfall && len >= lo && len <= int'(bus.max_len) && len <= MaxLen;
        endcase
      end
    end
    @(negedge clk);
    last_det = bus.detected;
    check({tag, ".det"}, 64'(bus.detected), 64'(ed));
    @(posedge clk);
    for (int ch = 0; ch < NCh; ch++) begin
      ai    = bus.a[ch];
      rfall = prev[ch] && !ai;
      len   = trail(ch);
      if (bus.en[ch]) begin
        if (rfall) begin
          lastlen[ch] = len;
          if (len == MaxLen + 1) ovl[ch] = 1'b1;
        end
        hist[ch].push_back(ai);
        if (hist[ch].size() > 16) void'(hist[ch].pop_front());
      end else begin
        hist[ch].delete();
      end
      prev[ch] = ai;
    end
    #1;
    check_regs(tag);
  endtask

  // Asserted shortly after a posedge; outputs checked while reset is still held.
  task automatic do_reset(input string tag);
    logic [3:0] ed;
    #1;
    rst = 1'b1;
    #1;
    ed = (bus.mode == 2'd0 || bus.mode == 2'd2) ? (bus.a & bus.en) : 4'h0;
    model_clear();
    check({tag, ".rst_det"}, 64'(bus.detected), 64'(ed));
    check_regs({tag, ".rst"});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse(input string tag, input int ch, input int len, output bit det);
    for (int k = 0; k < len; k++) begin
      bus.a[ch] = 1'b1;
      step(tag);
    end
    bus.a[ch] = 1'b0;
    step(tag);
    det = last_det[ch];
    step(tag);
  endtask

  initial begin
    bit d;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    drive(4'h0, 4'hF, 2'd0, 4'd1, 4'd1);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    check("reset.det", 64'(bus.detected), 64'h0);
    rst = 1'b0;

    // 1: rising edge on ch0
    drive(4'h0, 4'hF, 2'd0, 4'd1, 4'd1); step("t1");
    check("t1.s0", 64'(last_det), 64'h0);
    bus.a[0] = 1'b1; step("t1");
    check("t1.s1", 64'(last_det), 64'h1);
    step("t1");
    check("t1.s2", 64'(last_det), 64'h0);
    bus.a[0] = 1'b0; step("t1");
    check("t1.s3", 64'(last_det), 64'h0);

    // 2: 010 detector on ch1, including a pulse starting right after reset
    drive(4'h0, 4'hF, 2'd3, 4'd1, 4'd1);
    do_reset("t2");
    bus.a[1] = 1'b1; step("t2");
    bus.a[1] = 1'b0; step("t2");
    check("t2.first", 64'(last_det[1]), 64'h1);
    check("t2.len1", 64'(bus.last_len[7:4]), 64'd1);
    step("t2");
    bus.a[1] = 1'b1; step("t2");
    bus.a[1] = 1'b0; step("t2");
    check("t2.first_post", 64'(last_det[1]), 64'h1);
    bus.a[1] = 1'b1; step("t2"); step("t2");
    bus.a[1] = 1'b0; step("t2");
    check("t2.len2_nodet", 64'(last_det[1]), 64'h0);
    check("t2.len2", 64'(bus.last_len[7:4]), 64'd2);

    // 3: window 2..4 on ch2
    drive(4'h0, 4'hF, 2'd3, 4'd2, 4'd4);
    pulse("t3", 2, 1, d); check("t3.p1", 64'(d), 64'h0);
    pulse("t3", 2, 2, d); check("t3.p2", 64'(d), 64'h1);
    pulse("t3", 2, 4, d); check("t3.p4", 64'(d), 64'h1);
    pulse("t3", 2, 5, d); check("t3.p5", 64'(d), 64'h0);
    drive(4'h0, 4'hF, 2'd3, 4'd5, 4'd3);
    pulse("t3.empty", 2, 4, d); check("t3.empty", 64'(d), 64'h0);

    // 4: overlong pulse on ch3, even with max_len beyond MAX_LEN
    drive(4'h0, 4'hF, 2'd3, 4'd0, 4'd15);
    pulse("t4", 3, 12, d);
    check("t4.nodet", 64'(d), 64'h0);
    check("t4.len9", 64'(bus.last_len[15:12]), 64'd9);
    check("t4.ovl", 64'(bus.overlong[3]), 64'h1);
    pulse("t4", 3, 3, d);
    check("t4.short", 64'(d), 64'h1);
    check("t4.sticky", 64'(bus.overlong[3]), 64'h1);

    // 5: enable gating and reset mid-pulse
    drive(4'h0, 4'hE, 2'd2, 4'd1, 4'd1);
    for (int k = 0; k < 4; k++) begin
      bus.a[0] = ~bus.a[0]; step("t5.off");
      check("t5.off", 64'(last_det[0]), 64'h0);
    end
    bus.mode = 2'd0; bus.a[0] = 1'b1; step("t5.off");
    bus.en[0] = 1'b1; step("t5.en");
    check("t5.no_rise", 64'(last_det[0]), 64'h0);
    bus.a = 4'hF; bus.mode = 2'd3; step("t5"); step("t5");
    do_reset("t5");
    step("t5.post"); step("t5.post");
    bus.a = 4'h0; step("t5.post");
    check("t5.post_len", 64'(bus.last_len), 64'h2222);

    // 6: simultaneous any-edge, then mode change mid-pulse
    drive(4'h0, 4'hF, 2'd2, 4'd3, 4'd3);
    do_reset("t6");
    step("t6");
    bus.a = 4'hF; step("t6");
    check("t6.all", 64'(last_det), 64'hF);
    step("t6");
    check("t6.hold", 64'(last_det), 64'h0);
    bus.a = 4'h1; step("t6");
    bus.mode = 2'd3; bus.a = 4'h0; step("t6");
    check("t6.mode_chg", 64'(last_det[0]), 64'h1);
    check("t6.len3", 64'(bus.last_len[3:0]), 64'd3);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] en_r;
      en_r = 4'($urandom) | 4'($urandom);
      drive(4'($urandom_range(0, 15)) & 4'($urandom | $urandom), en_r,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 12)));
      if ($urandom_range(0, 99) == 0) do_reset("rnd");
      else step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
